// File: rtl/uart_cmd_engine_if.sv
// UART-side byte handshake between a host link and uart_cmd_engine.
// master drives received bytes and the tx sink ready; slave is the engine.
interface uart_cmd_engine_if;
  logic [7:0] uart_rx_data;
  logic       uart_rx_valid;
  logic       uart_rx_ready;
  logic [7:0] uart_tx_data;
  logic       uart_tx_valid;
  logic       uart_tx_ready;

  modport master (
    output uart_rx_data, uart_rx_valid, uart_tx_ready,
    input  uart_rx_ready, uart_tx_data, uart_tx_valid
  );

  modport slave (
    input  uart_rx_data, uart_rx_valid, uart_tx_ready,
    output uart_rx_ready, uart_tx_data, uart_tx_valid
  );
endinterface

// File: rtl/uart_cmd_engine.sv
// Framed UART command engine: parses SYNC/CMD/LEN/payload/CKSUM frames,
// executes injection/filter/mode/ping commands and replies with ACK/NAK pairs.
module uart_cmd_engine #(
  parameter int MAX_PAYLOAD    = 16,
  parameter int NUM_CH         = 2,
  parameter int CH_BYTES       = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                         clk,
  input  logic                         rst,
  uart_cmd_engine_if.slave             uart,
  output logic [NUM_CH*CH_BYTES*8-1:0] inject_report,
  output logic [NUM_CH-1:0]            inject_valid,
  input  logic [NUM_CH-1:0]            inject_ack,
  output logic [31:0]                  filter_mask,
  output logic                         mode_proxy,
  output logic                         mode_host
);
  localparam int IW = $clog2(MAX_PAYLOAD);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = NUM_CH * CH_BYTES * 8;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] SYNC        = 8'hA5;
  localparam logic [7:0] ACK         = 8'h06;
  localparam logic [7:0] NAK         = 8'h15;
  localparam logic [7:0] ERR_CKSUM   = 8'h01;
  localparam logic [7:0] ERR_LEN     = 8'h02;
  localparam logic [7:0] ERR_CMD     = 8'h03;
  localparam logic [7:0] ERR_BUSY    = 8'h04;
  localparam logic [7:0] ERR_TIMEOUT = 8'h05;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_LEN, S_PAYLOAD, S_CKSUM, S_EXEC, S_RESP0, S_RESP1
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        idx_q, idx_d;
  logic [7:0]        sum_q, sum_d;
  logic [7:0]        err_q, err_d;
  logic              cksum_ok_q, cksum_ok_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [7:0]        buf_q [MAX_PAYLOAD];
  logic [7:0]        buf_d [MAX_PAYLOAD];
  logic [RW-1:0]     report_q, report_d;
  logic [NUM_CH-1:0] inj_valid_q, inj_valid_d, inj_set;
  logic [31:0]       mask_q, mask_d;
  logic              proxy_q, proxy_d;
  logic              host_q, host_d;

  logic       rx_ready, rx_fire, in_frame;
  logic       is_inject, ch_busy, cmd_known;
  logic [7:0] len_need, exec_err, tx_data;

  // Command decode and error classification, highest priority first.
  always_comb begin
    is_inject = 1'b0;
    ch_busy   = 1'b0;
    cmd_known = 1'b1;
    len_need  = 8'd0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (cmd_q == 8'(8'h10 + c)) begin
        is_inject = 1'b1;
        ch_busy   = inj_valid_q[c];
      end
    end
    if (is_inject) begin
      len_need = 8'(CH_BYTES);
    end else begin
      case (cmd_q)
        8'h20:   len_need = 8'd4;
        8'h21:   len_need = 8'd1;
        8'h30:   len_need = 8'd0;
        default: cmd_known = 1'b0;
      endcase
    end
    if (!cksum_ok_q) begin
      exec_err = ERR_CKSUM;
    end else if (len_q > 8'(MAX_PAYLOAD) || (cmd_known && len_q != len_need)) begin
      exec_err = ERR_LEN;
    end else if (!cmd_known) begin
      exec_err = ERR_CMD;
    end else if (ch_busy) begin
      exec_err = ERR_BUSY;
    end else begin
      exec_err = 8'd0;
    end
  end

  assign rx_ready = (state_q == S_IDLE) || (state_q == S_CMD) || (state_q == S_LEN) ||
                    (state_q == S_PAYLOAD) || (state_q == S_CKSUM);
  assign rx_fire  = uart.uart_rx_valid && rx_ready;
  assign in_frame = rx_ready && (state_q != S_IDLE);

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    len_d      = len_q;
    idx_d      = idx_q;
    sum_d      = sum_q;
    err_d      = err_q;
    cksum_ok_d = cksum_ok_q;
    timer_d    = timer_q;
    buf_d      = buf_q;
    report_d   = report_q;
    mask_d     = mask_q;
    proxy_d    = proxy_q;
    host_d     = host_q;
    inj_set    = '0;

    if (state_q == S_IDLE) begin
      if (rx_fire && uart.uart_rx_data == SYNC) begin
        state_d = S_CMD;
        timer_d = '0;
      end
    end else if (in_frame) begin
      if (rx_fire) begin
        timer_d = '0;
        if (state_q == S_CMD) begin
          cmd_d   = uart.uart_rx_data;
          sum_d   = uart.uart_rx_data;
          state_d = S_LEN;
        end else if (state_q == S_LEN) begin
          len_d   = uart.uart_rx_data;
          sum_d   = sum_q + uart.uart_rx_data;
          idx_d   = 8'd0;
          state_d = (uart.uart_rx_data == 8'd0) ? S_CKSUM : S_PAYLOAD;
        end else if (state_q == S_PAYLOAD) begin
          // Oversized payloads still count toward the checksum but are not kept.
          if (idx_q < 8'(MAX_PAYLOAD)) begin
            buf_d[idx_q[IW-1:0]] = uart.uart_rx_data;
          end
          sum_d = sum_q + uart.uart_rx_data;
          idx_d = idx_q + 8'd1;
          if (idx_q == len_q - 8'd1) begin
            state_d = S_CKSUM;
          end
        end else begin
          cksum_ok_d = (uart.uart_rx_data == sum_q);
          state_d    = S_EXEC;
        end
      end else if (timer_q == TIMER_LAST) begin
        err_d   = ERR_TIMEOUT;
        state_d = S_RESP0;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end else if (state_q == S_EXEC) begin
      err_d   = exec_err;
      state_d = S_RESP0;
      if (exec_err == 8'd0) begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (cmd_q == 8'(8'h10 + c)) begin
            inj_set[c] = 1'b1;
            for (int i = 0; i < CH_BYTES; i++) begin
              report_d[c*CH_BYTES*8 + i*8 +: 8] = buf_q[i];
            end
          end
        end
        if (cmd_q == 8'h20) begin
          mask_d = {buf_q[3], buf_q[2], buf_q[1], buf_q[0]};
        end
        if (cmd_q == 8'h21) begin
          proxy_d = buf_q[0][0];
          host_d  = buf_q[0][1];
        end
      end
    end else if (state_q == S_RESP0) begin
      if (uart.uart_tx_ready) state_d = S_RESP1;
    end else begin
      if (uart.uart_tx_ready) state_d = S_IDLE;
    end
  end

  // A new request for a channel overrides an acknowledge in the same cycle.
  assign inj_valid_d = (inj_valid_q & ~inject_ack) | inj_set;

  always_comb begin
    tx_data = 8'h00;
    if (state_q == S_RESP0) begin
      tx_data = (err_q == 8'd0) ? ACK : NAK;
    end else if (state_q == S_RESP1) begin
      tx_data = (err_q == 8'd0) ? cmd_q : err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cmd_q       <= 8'd0;
      len_q       <= 8'd0;
      idx_q       <= 8'd0;
      sum_q       <= 8'd0;
      err_q       <= 8'd0;
      cksum_ok_q  <= 1'b0;
      timer_q     <= '0;
      report_q    <= '0;
      inj_valid_q <= '0;
      mask_q      <= 32'hFFFF_FFFF;
      proxy_q     <= 1'b1;
      host_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      err_q       <= err_d;
      cksum_ok_q  <= cksum_ok_d;
      timer_q     <= timer_d;
      report_q    <= report_d;
      inj_valid_q <= inj_valid_d;
      mask_q      <= mask_d;
      proxy_q     <= proxy_d;
      host_q      <= host_d;
    end
  end

  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign uart.uart_rx_ready = rx_ready;
  assign uart.uart_tx_valid = (state_q == S_RESP0) || (state_q == S_RESP1);
  assign uart.uart_tx_data  = tx_data;
  assign inject_report      = report_q;
  assign inject_valid       = inj_valid_q;
  assign filter_mask        = mask_q;
  assign mode_proxy         = proxy_q;
  assign mode_host          = host_q;
endmodule
